// File: rtl/pwm_tone_seq_if.sv
// Signal bundle between the tone sequencer and its surroundings: frame pacing
// and melody select in, PWM audio plus playback status out.
interface pwm_tone_seq_if;
    logic       frame_tick;
    logic [1:0] audio_select;
    logic       pwm_out;
    logic [2:0] note_idx;
    logic       playing;

    // Side that drives the sequencer (timing stage / control logic).
    modport master (
        output frame_tick,
        output audio_select,
        input  pwm_out,
        input  note_idx,
        input  playing
    );

    // The sequencer itself.
    modport slave (
        input  frame_tick,
        input  audio_select,
        output pwm_out,
        output note_idx,
        output playing
    );
endinterface

// File: rtl/pwm_tone_seq.sv
// 8-step melody sequencer producing a square-wave tone through a 1-bit PWM.
// The note changes every NOTE_FRAMES video frames. Volume starts at full
// scale on each note and decays on every frame of that note. The decayed
// volume sets the PWM duty while the tone square wave is high.
module pwm_tone_seq #(
    parameter int NOTE_FRAMES = 15,
    parameter int VOL_DECAY   = 8
) (
    input  logic            clk,
    input  logic            rst,
    pwm_tone_seq_if.slave   bus
);

    localparam int FW = (NOTE_FRAMES > 1) ? $clog2(NOTE_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(NOTE_FRAMES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Note code for a melody step; code 0 is a rest.
    function automatic logic [3:0] melody_code(input logic [1:0] sel,
                                               input logic [2:0] idx);
        logic [3:0] code;
        case (sel)
            2'b01:   code = {1'b0, idx} + 4'd1;
            2'b10:   code = 4'd8 - {1'b0, idx};
            2'b11: begin
                case (idx)
                    3'd0:    code = 4'd1;
                    3'd2:    code = 4'd3;
                    3'd4:    code = 4'd5;
                    3'd6:    code = 4'd8;
                    default: code = 4'd0;
                endcase
            end
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Tone half-period in clk cycles (C4..C5 at 25.175 MHz); 0 for a rest.
    function automatic logic [15:0] half_period(input logic [3:0] code);
        logic [15:0] hp;
        case (code)
            4'd1:    hp = 16'd48112;
            4'd2:    hp = 16'd42864;
            4'd3:    hp = 16'd38187;
            4'd4:    hp = 16'd36044;
            4'd5:    hp = 16'd32111;
            4'd6:    hp = 16'd28608;
            4'd7:    hp = 16'd25487;
            4'd8:    hp = 16'd24056;
            default: hp = 16'd0;
        endcase
        return hp;
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [2:0]     note_idx_q, note_idx_d;
    logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0]    tone_cnt_q, tone_cnt_d;
    logic           phase_q, phase_d;
    logic [7:0]     volume_q, volume_d;
    logic [7:0]     pwm_cnt_q, pwm_cnt_d;
    logic           pwm_out_q, pwm_out_d;

    logic           chg_s;
    logic           playing_s;
    logic [3:0]     code_s;
    logic [15:0]    hp_s;

    // A select change is any difference between the registered and live select.
    always_comb begin
        chg_s  = (sel_q != bus.audio_select);
        code_s = melody_code(sel_q, note_idx_q);
        hp_s   = half_period(code_s);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a change to 00 mutes, a change to any nonzero select plays.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (chg_s && (bus.audio_select != 2'b00)) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (chg_s && (bus.audio_select == 2'b00)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the playing flag is a decode of the state register.
    always_comb begin
        playing_s = 1'b0;
        case (state_q)
            ST_IDLE: playing_s = 1'b0;
            ST_PLAY: playing_s = 1'b1;
            default: playing_s = 1'b0;
        endcase
    end

    // Datapath next values: a select change overrides everything, including a
    // coincident frame_tick; the last frame of a note advances to the next step.
    always_comb begin
        sel_d       = bus.audio_select;
        note_idx_d  = note_idx_q;
        frame_cnt_d = frame_cnt_q;
        tone_cnt_d  = tone_cnt_q;
        phase_d     = phase_q;
        volume_d    = volume_q;
        pwm_cnt_d   = pwm_cnt_q + 8'd1;
        pwm_out_d   = playing_s & (code_s != 4'd0) & phase_q & (pwm_cnt_q < volume_q);

        if (chg_s) begin
            note_idx_d  = 3'd0;
            frame_cnt_d = '0;
            tone_cnt_d  = 16'd0;
            phase_d     = 1'b0;
            volume_d    = 8'd255;
        end else if (playing_s) begin
            if (bus.frame_tick && (frame_cnt_q == FRAME_LAST)) begin
                frame_cnt_d = '0;
                note_idx_d  = note_idx_q + 3'd1;
                volume_d    = 8'd255;
                tone_cnt_d  = 16'd0;
                phase_d     = 1'b0;
            end else begin
                if (bus.frame_tick) begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                    // Saturating decay so a long note never wraps back to loud.
                    if (int'(volume_q) > VOL_DECAY) begin
                        volume_d = volume_q - 8'(VOL_DECAY);
                    end else begin
                        volume_d = 8'd0;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end

                if (code_s == 4'd0) begin
                    tone_cnt_d = 16'd0;
                end else if (tone_cnt_q == (hp_s - 16'd1)) begin
                    tone_cnt_d = 16'd0;
                    phase_d    = ~phase_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + 16'd1;
                end
            end
        end else begin
            note_idx_d  = 3'd0;
            frame_cnt_d = '0;
            tone_cnt_d  = 16'd0;
            phase_d     = 1'b0;
        end
    end

    // Datapath registers with synchronous reset to a silent, idle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 2'b00;
            note_idx_q  <= 3'd0;
            frame_cnt_q <= '0;
            tone_cnt_q  <= 16'd0;
            phase_q     <= 1'b0;
            volume_q    <= 8'd0;
            pwm_cnt_q   <= 8'd0;
            pwm_out_q   <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            note_idx_q  <= note_idx_d;
            frame_cnt_q <= frame_cnt_d;
            tone_cnt_q  <= tone_cnt_d;
            phase_q     <= phase_d;
            volume_q    <= volume_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pwm_out_q   <= pwm_out_d;
        end
    end

    assign bus.pwm_out  = pwm_out_q;
    assign bus.note_idx = note_idx_q;
    assign bus.playing  = playing_s;

endmodule

// File: tb/tb_pwm_tone_seq.sv
// Directed bench for pwm_tone_seq: a default instance plus a NOTE_FRAMES=40
// instance used to reach volume saturation within a single note.
module tb_pwm_tone_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    pwm_tone_seq_if bus();
    pwm_tone_seq_if bus40();

    pwm_tone_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pwm_tone_seq #(.NOTE_FRAMES(40), .VOL_DECAY(8)) dut40 (
        .clk (clk),
        .rst (rst),
        .bus (bus40)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic tick_gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            step();
            step();
        end
    endtask

    task automatic test_reset();
        bus.audio_select   = 2'b01;
        bus.frame_tick     = 1'b0;
        bus40.audio_select = 2'b01;
        bus40.frame_tick   = 1'b0;
        rst = 1'b1;
        step();
        step();
        n_checks++; if (bus.playing !== 1'b0) $display("FAIL reset_playing got %b want 0", bus.playing); else n_pass++;
        n_checks++; if (bus.note_idx !== 3'd0) $display("FAIL reset_note got %0d want 0", bus.note_idx); else n_pass++;
        n_checks++; if (bus.pwm_out !== 1'b0) $display("FAIL reset_pwm got %b want 0", bus.pwm_out); else n_pass++;
        n_checks++; if (dut.volume_q !== 8'd0) $display("FAIL reset_volume got %0d want 0", dut.volume_q); else n_pass++;
        n_checks++; if (dut.sel_q !== 2'b00) $display("FAIL reset_sel got %b want 00", dut.sel_q); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++; if (bus.playing !== 1'b1) $display("FAIL start_playing got %b want 1", bus.playing); else n_pass++;
        n_checks++; if (bus.note_idx !== 3'd0) $display("FAIL start_note got %0d want 0", bus.note_idx); else n_pass++;
        n_checks++; if (dut.volume_q !== 8'd255) $display("FAIL start_volume got %0d want 255", dut.volume_q); else n_pass++;
        n_checks++; if (bus40.playing !== 1'b1) $display("FAIL start40_playing got %b want 1", bus40.playing); else n_pass++;
    endtask

    // Note 1 half-period is 48112: phase rises exactly 48112 edges after start.
    // Meanwhile dut40 gets 35 ticks in one note, saturating its volume at 0.
    task automatic test_phase_and_decay();
        int hi;
        int hi40;
        for (int i = 0; i < 48111; i++) begin
            bus40.frame_tick = ((i % 1000) == 500) && (i < 35000);
            step();
            bus40.frame_tick = 1'b0;
        end
        n_checks++; if (dut.phase_q !== 1'b0) $display("FAIL phase_before got %b want 0", dut.phase_q); else n_pass++;
        n_checks++; if (dut.tone_cnt_q !== 16'd48111) $display("FAIL tone_before got %0d want 48111", dut.tone_cnt_q); else n_pass++;
        step();
        n_checks++; if (dut.phase_q !== 1'b1) $display("FAIL phase_toggle got %b want 1", dut.phase_q); else n_pass++;
        n_checks++; if (dut.tone_cnt_q !== 16'd0) $display("FAIL tone_wrap got %0d want 0", dut.tone_cnt_q); else n_pass++;
        n_checks++; if (dut40.volume_q !== 8'd0) $display("FAIL sat_volume got %0d want 0", dut40.volume_q); else n_pass++;
        n_checks++; if (int'(dut40.frame_cnt_q) !== 35) $display("FAIL sat_frames got %0d want 35", dut40.frame_cnt_q); else n_pass++;
        n_checks++; if (dut40.phase_q !== 1'b1) $display("FAIL sat_phase got %b want 1", dut40.phase_q); else n_pass++;
        step();
        step();
        hi = 0;
        hi40 = 0;
        for (int i = 0; i < 256; i++) begin
            if (bus.pwm_out === 1'b1) hi++;
            if (bus40.pwm_out !== 1'b0) hi40++;
            step();
        end
        n_checks++; if (hi !== 255) $display("FAIL duty_full got %0d want 255", hi); else n_pass++;
        n_checks++; if (hi40 !== 0) $display("FAIL duty_zero got %0d want 0", hi40); else n_pass++;
    endtask

    task automatic test_mute();
        int bad;
        bus.audio_select = 2'b00;
        step();
        n_checks++; if (bus.playing !== 1'b0) $display("FAIL mute_playing got %b want 0", bus.playing); else n_pass++;
        step();
        n_checks++; if (bus.pwm_out !== 1'b0) $display("FAIL mute_pwm got %b want 0", bus.pwm_out); else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.pwm_out !== 1'b0 || bus.playing !== 1'b0 || bus.note_idx !== 3'd0) bad++;
            step();
            if (bus.pwm_out !== 1'b0 || dut.frame_cnt_q !== 4'd0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL mute_hold got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_staccato_rest();
        int bad_tone;
        int bad_pwm;
        bus.audio_select = 2'b11;
        step();
        n_checks++; if (dut.code_s !== 4'd1) $display("FAIL stac_code0 got %0d want 1", dut.code_s); else n_pass++;
        tick_gap(14);
        tick();
        n_checks++; if (bus.note_idx !== 3'd1) $display("FAIL stac_note got %0d want 1", bus.note_idx); else n_pass++;
        n_checks++; if (dut.code_s !== 4'd0) $display("FAIL stac_rest_code got %0d want 0", dut.code_s); else n_pass++;
        bad_tone = 0;
        bad_pwm = 0;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 3; k++) begin
                bus.frame_tick = (k == 0);
                step();
                bus.frame_tick = 1'b0;
                if (dut.tone_cnt_q !== 16'd0) bad_tone++;
                if (bus.pwm_out !== 1'b0) bad_pwm++;
            end
        end
        n_checks++; if (bad_tone !== 0) $display("FAIL rest_tone got %0d bad want 0", bad_tone); else n_pass++;
        n_checks++; if (bad_pwm !== 0) $display("FAIL rest_pwm got %0d bad want 0", bad_pwm); else n_pass++;
        n_checks++; if (bus.note_idx !== 3'd1) $display("FAIL rest_note_hold got %0d want 1", bus.note_idx); else n_pass++;
    endtask

    task automatic test_change_with_tick();
        bus.audio_select = 2'b01;
        step();
        tick_gap(3);
        n_checks++; if (int'(dut.frame_cnt_q) !== 3) $display("FAIL pre_frames got %0d want 3", dut.frame_cnt_q); else n_pass++;
        bus.audio_select = 2'b10;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        n_checks++; if (bus.note_idx !== 3'd0) $display("FAIL chg_note got %0d want 0", bus.note_idx); else n_pass++;
        n_checks++; if (int'(dut.frame_cnt_q) !== 0) $display("FAIL chg_frames got %0d want 0", dut.frame_cnt_q); else n_pass++;
        n_checks++; if (dut.code_s !== 4'd8) $display("FAIL chg_code got %0d want 8", dut.code_s); else n_pass++;
        n_checks++; if (dut.volume_q !== 8'd255) $display("FAIL chg_volume got %0d want 255", dut.volume_q); else n_pass++;
        n_checks++; if (bus.playing !== 1'b1) $display("FAIL chg_playing got %b want 1", bus.playing); else n_pass++;
        step();
        n_checks++; if (int'(dut.frame_cnt_q) !== 0) $display("FAIL chg_tick_lost got %0d want 0", dut.frame_cnt_q); else n_pass++;
    endtask

    task automatic test_advance();
        bus.audio_select = 2'b01;
        step();
        tick_gap(14);
        n_checks++; if (dut.volume_q !== 8'd143) $display("FAIL decay14 got %0d want 143", dut.volume_q); else n_pass++;
        n_checks++; if (int'(dut.frame_cnt_q) !== 14) $display("FAIL frames14 got %0d want 14", dut.frame_cnt_q); else n_pass++;
        n_checks++; if (bus.note_idx !== 3'd0) $display("FAIL note14 got %0d want 0", bus.note_idx); else n_pass++;
        tick();
        n_checks++; if (bus.note_idx !== 3'd1) $display("FAIL adv_note got %0d want 1", bus.note_idx); else n_pass++;
        n_checks++; if (int'(dut.frame_cnt_q) !== 0) $display("FAIL adv_frames got %0d want 0", dut.frame_cnt_q); else n_pass++;
        n_checks++; if (dut.volume_q !== 8'd255) $display("FAIL adv_volume got %0d want 255", dut.volume_q); else n_pass++;
        n_checks++; if (dut.hp_s !== 16'd42864) $display("FAIL adv_hp got %0d want 42864", dut.hp_s); else n_pass++;
        n_checks++; if (dut.tone_cnt_q !== 16'd0) $display("FAIL adv_tone got %0d want 0", dut.tone_cnt_q); else n_pass++;
        step();
        step();
        tick_gap(104);
        n_checks++; if (bus.note_idx !== 3'd7) $display("FAIL note119 got %0d want 7", bus.note_idx); else n_pass++;
        tick();
        n_checks++; if (bus.note_idx !== 3'd0) $display("FAIL wrap120 got %0d want 0", bus.note_idx); else n_pass++;
        step();
        tick_gap(20);
    endtask

    task automatic test_reset_midnote();
        n_checks++; if (bus.note_idx !== 3'd1) $display("FAIL mid_pre_note got %0d want 1", bus.note_idx); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (bus.playing !== 1'b0) $display("FAIL mid_rst_playing got %b want 0", bus.playing); else n_pass++;
        n_checks++; if (bus.note_idx !== 3'd0) $display("FAIL mid_rst_note got %0d want 0", bus.note_idx); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++; if (bus.playing !== 1'b1) $display("FAIL mid_restart got %b want 1", bus.playing); else n_pass++;
        n_checks++; if (dut.code_s !== 4'd1) $display("FAIL mid_restart_code got %0d want 1", dut.code_s); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_phase_and_decay();
        test_mute();
        test_staccato_rest();
        test_change_with_tick();
        test_advance();
        test_reset_midnote();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
